dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 64-bit storage words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to resp_valid (legal 1..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  memory stage presents a load/store.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_load  input  1  1=load, 0=store.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_wdata  input  64  store data, right-aligned.
REQ-010 SHALL have port req_size  input  2  0=byte, 1=half, 2=word, 3=dword.
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port req_rd  input  6  destination tag, returned unchanged.
REQ-013 SHALL have port resp_valid  output  1  response available.
REQ-014 SHALL have port resp_ready  input  1  memory stage consumes response.
REQ-015 SHALL have port resp_data  output  64  extended load data; 0 for stores.
REQ-016 SHALL have port resp_rd  output  6  tag of responded request.
REQ-017 SHALL have port resp_err  output  1  access faulted (see Configuration).

Function
REQ-018 SHALL implement states IDLE, BUSY, RESP; one request outstanding at most.
REQ-019 SHALL drive req_ready=1 only in IDLE; accept on req_valid&&req_ready at clock edge, capturing all req_* fields.
REQ-020 SHALL, on accept, load wait counter with LATENCY-1 and enter BUSY (LATENCY=1: counter 0).
REQ-021 SHALL decrement counter each BUSY cycle; at counter==0 perform the access and enter RESP.
REQ-022 SHALL assert resp_valid exactly LATENCY cycles after the accept edge, held with resp_data/resp_rd/resp_err stable until resp_ready.
REQ-023 SHALL return to IDLE on resp_valid&&resp_ready; req_ready high the following cycle (no same-cycle re-accept).
REQ-024 SHALL index storage with req_addr[3 +: log2(DEPTH_WORDS)]; higher address bits ignored (wrap-around).
REQ-025 SHALL, for stores, write only the byte lanes selected by size and addr[2:0], leaving other bytes unchanged; write occurs on the BUSY->RESP edge.
REQ-026 SHALL, for loads, extract the selected lanes and sign/zero-extend to 64 bits per req_unsigned; size 3 ignores req_unsigned.
REQ-027 SHALL ignore req_valid and all req_* while not in IDLE.
REQ-028 SHALL ignore resp_ready while not in RESP.

Reset
REQ-029 SHALL on reset force IDLE, counter=0, req_ready=1 next cycle, resp_valid=0, resp_data=0, resp_rd=0, resp_err=0.
REQ-030 SHALL on reset in BUSY drop the pending request; a store not yet written SHALL NOT modify storage.
REQ-031 SHALL NOT clear storage contents on reset.

Configuration
REQ-032 SHALL, with DMEM_ALIGN_CHECK_EN defined, treat address not aligned to size as fault: no storage write, resp_data=0, resp_err=1, same LATENCY timing.
REQ-033 SHALL, without DMEM_ALIGN_CHECK_EN, clear addr low bits to natural alignment (half: bit0, word: bits1:0, dword: bits2:0) and resp_err tied 0.

Structure
REQ-034 SHALL place size encoding enum, state enum (IDLE/BUSY/RESP) and default DEPTH_WORDS/LATENCY constants in shared package dmem_pkg.
REQ-035 SHALL implement lane selection, store byte-enable/merge and load extract/extend in combinational sub-module dmem_lane_align.

Verification
REQ-036 SHALL test: reset, store dword 0x1122334455667788 at 0x40, LATENCY=2 -> resp_valid 2 cycles after accept, resp_data=0, resp_rd echoed; load dword 0x40 -> 0x1122334455667788.
REQ-037 SHALL test: load byte signed at 0x47 after REQ-036 store -> 0x0000000000000011; store byte 0x80 at 0x41 then load byte signed 0x41 -> 0xFFFFFFFFFFFFFF80, unsigned -> 0x80.
REQ-038 SHALL test: resp_ready held 0 for 5 cycles -> resp_valid, resp_data, resp_rd stable; req_ready=0 throughout; IDLE one cycle after handshake.
REQ-039 SHALL test: reset asserted in BUSY of store 0xDEAD to 0x80 -> resp_valid never rises, later load 0x80 returns previous contents.
REQ-040 SHALL test: DEPTH_WORDS=4096, store to 0x8040 then load 0x0040 -> same data (wrap).
REQ-041 SHALL test: half store at 0x43 -> with DMEM_ALIGN_CHECK_EN resp_err=1, no write; without, write lands at 0x42, resp_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE  = 2'd0,
      SIZE_HALF  = 2'd1,
      SIZE_WORD  = 2'd2,
      SIZE_DWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_DEPTH_WORDS = 4096;
   localparam int unsigned DEFAULT_LATENCY     = 2;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane selection, store merge and load extract/extend for one 64-bit word.
// With DMEM_ALIGN_CHECK_EN defined a misaligned access faults; otherwise the offset is force-aligned.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_e       size,
   input  logic [2:0]  addr_low,
   input  logic [63:0] wdata,
   input  logic        is_unsigned,
   input  logic [63:0] word_in,
   output logic        fault,
   output logic [63:0] word_out,
   output logic [63:0] load_data
);

   logic [2:0]  mask;
   logic [2:0]  off;
   logic [7:0]  be_base;
   logic [7:0]  be;
   logic [63:0] wsh;
   logic [63:0] rsh;

   always_comb begin
      mask    = 3'b000;
      be_base = 8'h01;
      case (size)
         SIZE_BYTE:  begin mask = 3'b000; be_base = 8'h01; end
         SIZE_HALF:  begin mask = 3'b001; be_base = 8'h03; end
         SIZE_WORD:  begin mask = 3'b011; be_base = 8'h0F; end
         SIZE_DWORD: begin mask = 3'b111; be_base = 8'hFF; end
         default:    begin mask = 3'b000; be_base = 8'h01; end
      endcase
   end

`ifdef DMEM_ALIGN_CHECK_EN
   assign fault = |(addr_low & mask);
   assign off   = addr_low;
`else
   assign fault = 1'b0;
   assign off   = addr_low & ~mask;
`endif

   assign be  = be_base << off;
   assign wsh = wdata << {off, 3'b000};
   assign rsh = word_in >> {off, 3'b000};

   always_comb begin
      word_out = word_in;
      for (int unsigned i = 0; i < 8; i++) begin
         if (be[i]) word_out[8*i +: 8] = wsh[8*i +: 8];
      end
   end

   always_comb begin
      load_data = '0;
      case (size)
         SIZE_BYTE:  load_data = is_unsigned ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
         SIZE_HALF:  load_data = is_unsigned ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
         SIZE_WORD:  load_data = is_unsigned ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
         SIZE_DWORD: load_data = rsh;
         default:    load_data = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed LATENCY from accept to response.
// DMEM_ALIGN_CHECK_EN turns misaligned accesses into faults instead of force-aligning them.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [5:0]  req_rd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic [5:0]  resp_rd,
   output logic        resp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   logic [63:0]      mem [DEPTH_WORDS];
   state_e           state;
   logic [3:0]       cnt;
   logic             load_q;
   logic [IDX_W-1:0] idx_q;
   logic [2:0]       low_q;
   logic [63:0]      wdata_q;
   size_e            size_q;
   logic             uns_q;
   logic [5:0]       rd_q;

   logic             fault;
   logic [63:0]      word_rd;
   logic [63:0]      word_wr;
   logic [63:0]      load_data;
   logic             access;
   logic             addr_unused;

   // Address bits above the storage index wrap around by design.
   assign addr_unused = ^req_addr[63:3+IDX_W];

   assign word_rd = mem[idx_q];
   assign access  = (state == BUSY) && (cnt == '0);

   dmem_lane_align u_lane (
      .size        (size_q),
      .addr_low    (low_q),
      .wdata       (wdata_q),
      .is_unsigned (uns_q),
      .word_in     (word_rd),
      .fault       (fault),
      .word_out    (word_wr),
      .load_data   (load_data)
   );

   // A reset during BUSY suppresses the write, so a dropped store never lands.
   always_ff @(posedge clk) begin
      if (!reset && access && !load_q && !fault) mem[idx_q] <= word_wr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
         load_q     <= 1'b0;
         idx_q      <= '0;
         low_q      <= '0;
         wdata_q    <= '0;
         size_q     <= SIZE_BYTE;
         uns_q      <= 1'b0;
         rd_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  load_q    <= req_load;
                  idx_q     <= req_addr[3 +: IDX_W];
                  low_q     <= req_addr[2:0];
                  wdata_q   <= req_wdata;
                  size_q    <= size_e'(req_size);
                  uns_q     <= req_unsigned;
                  rd_q      <= req_rd;
                  cnt       <= 4'(LATENCY - 1);
                  req_ready <= 1'b0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  resp_valid <= 1'b1;
                  resp_rd    <= rd_q;
                  resp_err   <= fault;
                  resp_data  <= (load_q && !fault) ? load_data : '0;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder with a byte-level reference memory.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int unsigned DEPTH = 4096;
   localparam int unsigned LAT   = 2;
   localparam int unsigned NBYTE = DEPTH * 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_load = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [5:0]  req_rd = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_data;
   logic [5:0]  resp_rd;
   logic        resp_err;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_load     (req_load),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_rd       (req_rd),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_rd      (resp_rd),
      .resp_err     (resp_err)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [5:0]  rd;
      logic        err;
   } resp_t;

   resp_t      sb[$];
   logic [7:0] mbytes [NBYTE];
   int         n_assert = 0;
   int         n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] mask_of(input logic [1:0] sz);
      return (sz == 2'd0) ? 3'd0 : (sz == 2'd1) ? 3'd1 : (sz == 2'd2) ? 3'd3 : 3'd7;
   endfunction

   function automatic logic fault_of(input logic [63:0] addr, input logic [1:0] sz);
`ifdef DMEM_ALIGN_CHECK_EN
      return |(addr[2:0] & mask_of(sz));
`else
      return (addr[0] & 1'b0) | (sz[0] & 1'b0);
`endif
   endfunction

   function automatic int unsigned base_of(input logic [63:0] addr, input logic [1:0] sz);
      logic [63:0] a;
      a = addr & ~{61'd0, mask_of(sz)};
      return int'(a % NBYTE);
   endfunction

   task automatic mdl_store(input logic [63:0] addr, input logic [1:0] sz, input logic [63:0] wd);
      int unsigned b;
      if (fault_of(addr, sz)) return;
      b = base_of(addr, sz);
      for (int i = 0; i < (1 << sz); i++) mbytes[b + i] = wd[8*i +: 8];
   endtask

   function automatic logic [63:0] mdl_load(input logic [63:0] addr, input logic [1:0] sz, input logic uns);
      logic [63:0] v;
      int unsigned b;
      int          n;
      if (fault_of(addr, sz)) return '0;
      b = base_of(addr, sz);
      n = 1 << sz;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[b + i];
      if (!uns && sz != 2'd3 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      return v;
   endfunction

   // One request: push the model's expectation, drive, then pop and compare on the response.
   task automatic transact(input logic ld, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [1:0] sz, input logic uns, input logic [5:0] rd,
                           input int hold, input string tag);
      resp_t e;
      int    n;
      e.rd   = rd;
      e.err  = fault_of(addr, sz);
      e.data = ld ? mdl_load(addr, sz, uns) : '0;
      if (!ld) mdl_store(addr, sz, wd);
      sb.push_back(e);

      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);

      req_valid = 1'b1; req_load = ld; req_addr = addr; req_wdata = wd;
      req_size = sz; req_unsigned = uns; req_rd = rd;
      @(posedge clk); #1;
      // Garbage on the request side must be ignored while busy.
      req_valid = 1'b1; req_load = ~ld; req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom}; req_rd = ~rd;
      resp_ready = 1'b1;

      n = 0;
      do begin
         @(posedge clk); #1; n++;
         if (!resp_valid) check({tag, "_busy_ready"}, {63'd0, req_ready}, 64'd0);
      end while (!resp_valid && n < 40);
      check({tag, "_latency"}, 64'(n), 64'(LAT));
      e = sb.pop_front();
      check({tag, "_data"}, resp_data, e.data);
      check({tag, "_rd"}, {58'd0, resp_rd}, {58'd0, e.rd});
      check({tag, "_err"}, {63'd0, resp_err}, {63'd0, e.err});
      req_valid = 1'b0;

      if (hold > 0) begin
         resp_ready = 1'b0;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {63'd0, resp_valid}, 64'd1);
            check({tag, "_hold_data"}, resp_data, e.data);
            check({tag, "_hold_rd"}, {58'd0, resp_rd}, {58'd0, e.rd});
            check({tag, "_hold_req_ready"}, {63'd0, req_ready}, 64'd0);
         end
         resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, "_done_valid"}, {63'd0, resp_valid}, 64'd0);
      check({tag, "_done_req_ready"}, {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      for (int i = 0; i < NBYTE; i++) mbytes[i] = '0;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_resp_data", resp_data, 64'd0);
      check("rst_resp_rd", {58'd0, resp_rd}, 64'd0);
      check("rst_resp_err", {63'd0, resp_err}, 64'd0);

      transact(1'b0, 64'h40, 64'h1122334455667788, 2'd3, 1'b0, 6'd5,  0, "st_dword_40");
      transact(1'b1, 64'h40, 64'h0,                2'd3, 1'b0, 6'd6,  0, "ld_dword_40");
      transact(1'b1, 64'h47, 64'h0,                2'd0, 1'b0, 6'd7,  0, "ld_byte_47");
      transact(1'b0, 64'h41, 64'h80,               2'd0, 1'b0, 6'd8,  0, "st_byte_41");
      transact(1'b1, 64'h41, 64'h0,                2'd0, 1'b0, 6'd9,  0, "ld_sbyte_41");
      transact(1'b1, 64'h41, 64'h0,                2'd0, 1'b1, 6'd10, 0, "ld_ubyte_41");
      transact(1'b1, 64'h40, 64'h0,                2'd1, 1'b0, 6'd11, 0, "ld_shalf_40");
      transact(1'b1, 64'h44, 64'h0,                2'd2, 1'b1, 6'd12, 0, "ld_uword_44");
      transact(1'b1, 64'h40, 64'h0,                2'd3, 1'b0, 6'd13, 5, "ld_hold_40");

      transact(1'b0, 64'h80, 64'h0123456789ABCDEF, 2'd3, 1'b0, 6'd14, 0, "st_dword_80");
      check("rstbusy_pre_ready", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_load = 1'b0; req_addr = 64'h80; req_wdata = 64'hDEAD;
      req_size = 2'd3; req_unsigned = 1'b0; req_rd = 6'd15;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rstbusy_req_ready", {63'd0, req_ready}, 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("rstbusy_no_resp", {63'd0, resp_valid}, 64'd0);
      end
      transact(1'b1, 64'h80, 64'h0, 2'd3, 1'b0, 6'd16, 0, "ld_after_rstbusy");

      transact(1'b0, 64'h8040, 64'hCAFEF00DDEADBEEF, 2'd3, 1'b0, 6'd17, 0, "st_wrap_8040");
      transact(1'b1, 64'h0040, 64'h0,                2'd3, 1'b0, 6'd18, 0, "ld_wrap_0040");

      transact(1'b0, 64'h43, 64'hBEEF, 2'd1, 1'b0, 6'd19, 0, "st_half_43");
      transact(1'b1, 64'h40, 64'h0,    2'd3, 1'b0, 6'd20, 0, "ld_after_half");
      transact(1'b1, 64'h43, 64'h0,    2'd1, 1'b1, 6'd21, 0, "ld_uhalf_43");
      transact(1'b1, 64'h42, 64'h0,    2'd1, 1'b0, 6'd22, 0, "ld_shalf_42");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
